// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Purpose:
//   Multi-port architectural register file with a per-register busy
//   scoreboard. There are NRD combinational read ports and two write ports.
//   Write port 1 has priority over write port 0. A reserve input sets a
//   register's busy bit, and any accepted write clears it. busy_cnt tracks
//   the number of busy registers. It is updated incrementally and always
//   equals the population count of the busy bits.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, a write in flight is forwarded to
//   matching read ports in the same cycle. Port 1 wins over port 0.
//   A same-cycle reserve still shows busy.
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst_n    in   asynchronous active-low reset, clears all state
//   ra       in   NRD*AW read addresses, port i at [i*AW +: AW]
//   rd       out  NRD*WIDTH read data, port i at [i*WIDTH +: WIDTH]
//   rbusy    out  NRD busy bit of the register addressed by each port
//   we0/wa0/wd0  in  write port 0
//   we1/wa1/wd1  in  write port 1 (higher priority)
//   rsv_en/rsv_a in  reserve (set busy) a register
//   busy_cnt out  AW+1 number of busy registers
//
// Handshake: there is none. Writes and reserves present on an edge are
//   always accepted.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rbusy,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [WIDTH-1:0]     wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [WIDTH-1:0]     wd1,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_a,
    output logic [AW:0]          busy_cnt
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    // Accesses to register 0 are dropped entirely when it is hard-wired to zero.
    logic wr0_ok, wr1_ok, rsv_ok;
    assign wr0_ok = we0    && !((ZERO_REG != 0) && (wa0   == '0));
    assign wr1_ok = we1    && !((ZERO_REG != 0) && (wa1   == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_a == '0));

    // Incremental count terms.
    // A clear only counts when the bit is set and no reserve to the same
    // register keeps it set. When both ports hit one register, that register
    // is counted once.
    logic inc, dec0, dec1;

    always_comb begin
        inc  = rsv_ok && !busy_q[rsv_a];
        dec0 = wr0_ok && busy_q[wa0] && !(rsv_ok && (rsv_a == wa0));
        dec1 = wr1_ok && busy_q[wa1] && !(rsv_ok && (rsv_a == wa1))
               && !(dec0 && (wa0 == wa1));
        cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec0) - (AW+1)'(dec1);
    end

    // The reserve is applied last, so it wins over a same-address clear.
    always_comb begin
        busy_d = busy_q;
        if (wr0_ok) busy_d[wa0]   = 1'b0;
        if (wr1_ok) busy_d[wa1]   = 1'b0;
        if (rsv_ok) busy_d[rsv_a] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr0_ok) mem_q[wa0] <= wd0;
            // Port 1 is assigned second, so it wins a same-address collision.
            if (wr1_ok) mem_q[wa1] <= wd1;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        logic             b;

        assign a = ra[i*AW +: AW];

        always_comb begin
            d = mem_q[a];
            b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is gated by rst_n so that outputs read zero while
            // reset is held.
            if (rst_n) begin
                if (wr0_ok && (wa0 == a)) begin
                    d = wd0;
                    b = 1'b0;
                end
                if (wr1_ok && (wa1 == a)) begin
                    d = wd1;
                    b = 1'b0;
                end
                if (rsv_ok && (rsv_a == a)) b = 1'b1;
            end
`endif
            if ((ZERO_REG != 0) && (a == '0)) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = d;
        assign rbusy[i]             = b;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- DUT A: default parameters ----------------
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rbusy;
    logic        a_we0, a_we1, a_rsv;
    logic [4:0]  a_wa0, a_wa1, a_rsv_a;
    logic [31:0] a_wd0, a_wd1;
    logic [5:0]  a_cnt;

    regfile_mp u_a (
        .clk(clk), .rst_n(rst_n), .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy),
        .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0),
        .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
        .rsv_en(a_rsv), .rsv_a(a_rsv_a), .busy_cnt(a_cnt)
    );

    // ---------------- DUT B: DEPTH=8, no zero register ----------------
    logic [2:0]  b_ra;
    logic [31:0] b_rd;
    logic [0:0]  b_rbusy;
    logic        b_we0, b_we1, b_rsv;
    logic [2:0]  b_wa0, b_wa1, b_rsv_a;
    logic [31:0] b_wd0, b_wd1;
    logic [3:0]  b_cnt;

    regfile_mp #(.WIDTH(32), .DEPTH(8), .NRD(1), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy),
        .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0),
        .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
        .rsv_en(b_rsv), .rsv_a(b_rsv_a), .busy_cnt(b_cnt)
    );

    // ---------------- DUT C: parameter sweep 16/64/4 ----------------
    logic [23:0] c_ra;
    logic [63:0] c_rd;
    logic [3:0]  c_rbusy;
    logic        c_we0, c_we1, c_rsv;
    logic [5:0]  c_wa0, c_wa1, c_rsv_a;
    logic [15:0] c_wd0, c_wd1;
    logic [6:0]  c_cnt;

    regfile_mp #(.WIDTH(16), .DEPTH(64), .NRD(4)) u_c (
        .clk(clk), .rst_n(rst_n), .ra(c_ra), .rd(c_rd), .rbusy(c_rbusy),
        .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0),
        .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1),
        .rsv_en(c_rsv), .rsv_a(c_rsv_a), .busy_cnt(c_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] m_reg [64];
    logic        m_busy [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Spec-level read of the sweep model, including same-cycle forwarding.
    function automatic logic [15:0] model_rd(input logic [5:0] a);
        if (a == 0) return 16'h0;
        if (BYP && c_we1 && c_wa1 == a) return c_wd1;
        if (BYP && c_we0 && c_wa0 == a) return c_wd0;
        return m_reg[a];
    endfunction

    function automatic logic model_rb(input logic [5:0] a);
        if (a == 0) return 1'b0;
        if (BYP && c_rsv && c_rsv_a == a) return 1'b1;
        if (BYP && ((c_we1 && c_wa1 == a) || (c_we0 && c_wa0 == a))) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int model_cnt();
        int s = 0;
        for (int k = 0; k < 64; k++) s += int'(m_busy[k]);
        return s;
    endfunction

    function automatic logic [5:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
        return 6'($urandom_range(0, 7));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic a_idle();
        a_we0 = 0; a_we1 = 0; a_rsv = 0;
    endtask

    // Leave the cycle's writes on for exactly one edge, then sample settled state.
    task automatic a_edge();
        @(posedge clk);
        #1 a_idle();
        #1;
    endtask

    typedef struct {
        logic we0; logic [4:0] wa0; logic [31:0] wd0;
        logic we1; logic [4:0] wa1; logic [31:0] wd1;
        logic rsv; logic [4:0] rsv_a;
        logic [4:0] ra0; logic [4:0] ra1;
        logic [31:0] e_rd0; logic e_rb0;
        logic [31:0] e_rd1; logic e_rb1;
        logic [5:0] e_cnt;
    } vec_t;

    vec_t vecs[11];

    // ---------------- stimulus ----------------
    initial begin
        a_idle(); a_ra = '0; a_wa0 = '0; a_wa1 = '0; a_wd0 = '0; a_wd1 = '0; a_rsv_a = '0;
        b_we0 = 0; b_we1 = 0; b_rsv = 0; b_ra = '0; b_wa0 = '0; b_wa1 = '0;
        b_wd0 = '0; b_wd1 = '0; b_rsv_a = '0;
        c_we0 = 0; c_we1 = 0; c_rsv = 0; c_ra = '0; c_wa0 = '0; c_wa1 = '0;
        c_wd0 = '0; c_wd1 = '0; c_rsv_a = '0;
        for (int k = 0; k < 64; k++) begin m_reg[k] = '0; m_busy[k] = 1'b0; end

        //          we0 wa0 wd0            we1 wa1 wd1            rsv ra  ra0 ra1 rd0            rb0 rd1            rb1 cnt
        vecs[0]  = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 4,  4,  9,  32'h0,          1, 32'h0,          0, 1};
        vecs[1]  = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 9,  4,  9,  32'h0,          1, 32'h0,          1, 2};
        vecs[2]  = '{1, 4, 32'h1234,       0, 0, 32'h0,          1, 4,  4,  9,  32'h1234,       1, 32'h0,          1, 2};
        vecs[3]  = '{1, 4, 32'hAAAA0004,   1, 9, 32'hBBBB0009,   0, 0,  4,  9,  32'hAAAA0004,   0, 32'hBBBB0009,   0, 0};
        vecs[4]  = '{1, 3, 32'h11111111,   1, 3, 32'h22222222,   0, 0,  3,  4,  32'h22222222,   0, 32'hAAAA0004,   0, 0};
        vecs[5]  = '{1, 0, 32'hFFFFFFFF,   0, 0, 32'h0,          1, 0,  0,  3,  32'h0,          0, 32'h22222222,   0, 0};
        vecs[6]  = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 5,  5,  0,  32'h0,          1, 32'h0,          0, 1};
        vecs[7]  = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 5,  5,  0,  32'h0,          1, 32'h0,          0, 1};
        vecs[8]  = '{0, 0, 32'h0,          1, 10, 32'h10,        0, 0,  10, 5,  32'h10,         0, 32'h0,          1, 1};
        vecs[9]  = '{1, 5, 32'h55,         1, 5, 32'h66,         0, 0,  5,  10, 32'h66,         0, 32'h10,         0, 0};
        vecs[10] = '{1, 5, 32'hDEADBEEF,   0, 0, 32'h0,          1, 7,  5,  7,  32'hDEADBEEF,   0, 32'h0,          1, 1};

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("reset_cnt_a", 32'(a_cnt), 32'd0);
        chk("reset_rd_a", a_rd[31:0], 32'd0);

        // ---- table-driven vectors on DUT A ----
        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            a_we0 = vecs[v].we0; a_wa0 = vecs[v].wa0; a_wd0 = vecs[v].wd0;
            a_we1 = vecs[v].we1; a_wa1 = vecs[v].wa1; a_wd1 = vecs[v].wd1;
            a_rsv = vecs[v].rsv; a_rsv_a = vecs[v].rsv_a;
            a_ra  = {vecs[v].ra1, vecs[v].ra0};
            a_edge();
            chk($sformatf("vec%0d_rd0", v), a_rd[31:0],  vecs[v].e_rd0);
            chk($sformatf("vec%0d_rb0", v), 32'(a_rbusy[0]), 32'(vecs[v].e_rb0));
            chk($sformatf("vec%0d_rd1", v), a_rd[63:32], vecs[v].e_rd1);
            chk($sformatf("vec%0d_rb1", v), 32'(a_rbusy[1]), 32'(vecs[v].e_rb1));
            chk($sformatf("vec%0d_cnt", v), 32'(a_cnt), 32'(vecs[v].e_cnt));
        end

        // ---- asynchronous reset mid-cycle, with a write/reserve held on ----
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd0", a_rd[31:0], 32'd0);
        chk("rst_rd1", a_rd[63:32], 32'd0);
        chk("rst_rb",  32'(a_rbusy), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        a_we0 = 1; a_wa0 = 5; a_wd0 = 32'h1; a_rsv = 1; a_rsv_a = 7;
        @(posedge clk);
        #1;
        chk("rst_wins_rd0", a_rd[31:0], 32'd0);
        chk("rst_wins_rb1", 32'(a_rbusy[1]), 32'd0);
        chk("rst_wins_cnt", 32'(a_cnt), 32'd0);
        @(negedge clk);
        a_idle();
        rst_n = 1'b1;

        // ---- forwarding: reg6 = 0 and busy, then write it ----
        a_ra = {5'd6, 5'd0};
        @(negedge clk);
        a_rsv = 1; a_rsv_a = 6;
        a_edge();
        chk("byp_pre_rb1", 32'(a_rbusy[1]), 32'd1);
        @(negedge clk);
        a_we0 = 1; a_wa0 = 6; a_wd0 = 32'hA5A5A5A5;
        #2;
        chk("byp_same_rd1", a_rd[63:32], BYP ? 32'hA5A5A5A5 : 32'h0);
        chk("byp_same_rb1", 32'(a_rbusy[1]), BYP ? 32'd0 : 32'd1);
        a_edge();
        chk("byp_after_rd1", a_rd[63:32], 32'hA5A5A5A5);
        chk("byp_after_rb1", 32'(a_rbusy[1]), 32'd0);
        chk("byp_after_cnt", 32'(a_cnt), 32'd0);
        // Both ports write the read address: port 1 is forwarded.
        @(negedge clk);
        a_ra = {5'd6, 5'd8};
        a_we0 = 1; a_wa0 = 8; a_wd0 = 32'h1;
        a_we1 = 1; a_wa1 = 8; a_wd1 = 32'h2;
        #2;
        chk("byp_prio_rd0", a_rd[31:0], BYP ? 32'h2 : 32'h0);
        a_edge();
        chk("byp_prio_after", a_rd[31:0], 32'h2);
        // A write and a reserve of the read address: still shows busy.
        @(negedge clk);
        a_we0 = 1; a_wa0 = 6; a_wd0 = 32'h77; a_rsv = 1; a_rsv_a = 6;
        #2;
        chk("byp_rsv_rb1", 32'(a_rbusy[1]), BYP ? 32'd1 : 32'd0);
        chk("byp_rsv_rd1", a_rd[63:32], BYP ? 32'h77 : 32'hA5A5A5A5);
        a_edge();
        chk("byp_rsv_after_rb1", 32'(a_rbusy[1]), 32'd1);
        chk("byp_rsv_after_cnt", 32'(a_cnt), 32'd1);

        // ---- DUT B: reserve every register, no wrap, then clear two per edge ----
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b_rsv = 1; b_rsv_a = 3'(k);
            @(posedge clk);
            #1 b_rsv = 0;
            #1 chk($sformatf("b_fill_cnt%0d", k), 32'(b_cnt), 32'(k + 1));
        end
        @(negedge clk);
        b_rsv = 1; b_rsv_a = 3; b_ra = 0;
        @(posedge clk);
        #1 b_rsv = 0;
        #1;
        chk("b_full_cnt", 32'(b_cnt), 32'd8);
        chk("b_reg0_busy", 32'(b_rbusy[0]), 32'd1);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            b_we0 = 1; b_wa0 = 3'(2 * j);     b_wd0 = 32'(100 + j);
            b_we1 = 1; b_wa1 = 3'(2 * j + 1); b_wd1 = 32'(200 + j);
            b_ra  = 3'(2 * j + 1);
            @(posedge clk);
            #1 begin b_we0 = 0; b_we1 = 0; end
            #1;
            chk($sformatf("b_drain_cnt%0d", j), 32'(b_cnt), 32'(6 - 2 * j));
            chk($sformatf("b_drain_rd%0d", j), b_rd, 32'(200 + j));
        end

        // ---- DUT C: random traffic against the reference model ----
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            c_we0 = 1'($urandom_range(0, 1)); c_wa0 = rand_addr(); c_wd0 = 16'($urandom);
            c_we1 = 1'($urandom_range(0, 1)); c_wa1 = rand_addr(); c_wd1 = 16'($urandom);
            c_rsv = 1'($urandom_range(0, 1)); c_rsv_a = rand_addr();
            for (int p = 0; p < 4; p++) c_ra[p*6 +: 6] = rand_addr();
            #2;
            for (int p = 0; p < 4; p++) exp_q.push_back(model_rd(c_ra[p*6 +: 6]));
            for (int p = 0; p < 4; p++) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk($sformatf("c_rd%0d", p), 32'(c_rd[p*16 +: 16]), 32'(e));
                chk($sformatf("c_rb%0d", p), 32'(c_rbusy[p]), 32'(model_rb(c_ra[p*6 +: 6])));
            end
            chk("c_cnt", 32'(c_cnt), 32'(model_cnt()));
            @(posedge clk);
            // Apply the edge's effect in spec order: writes, port 1 last, then reserve.
            if (c_we0 && c_wa0 != 0) begin m_reg[c_wa0] = c_wd0; m_busy[c_wa0] = 1'b0; end
            if (c_we1 && c_wa1 != 0) begin m_reg[c_wa1] = c_wd1; m_busy[c_wa1] = 1'b0; end
            if (c_rsv && c_rsv_a != 0) m_busy[c_rsv_a] = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with a per-register busy scoreboard, intended as the next-generation architectural register file for the pipelined core. It provides a configurable number of combinational read ports and two prioritised write ports, and tracks pending writebacks. All contents and state clear on asynchronous reset. It sits between decode/issue, which reads operands and reserves destinations, and writeback, which writes results and clears reservations.

## Interface
- `WIDTH`, 32, data bits per register.
- `DEPTH`, 32, number of registers; must be a power of two, ≥ 2.
- `NRD`, 2, number of read ports, 1..8.
- `ZERO_REG`, 1, when 1 register 0 reads as 0, ignores writes, and cannot be reserved.
- Derived: `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ra`  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- `rd`  out  NRD*WIDTH  read data; port i uses bits [i*WIDTH +: WIDTH].
- `rbusy`  out  NRD  busy bit of the register addressed by each read port.
- `we0`, `wa0`, `wd0`  in  1 / AW / WIDTH  write port 0.
- `we1`, `wa1`, `wd1`  in  1 / AW / WIDTH  write port 1; higher priority.
- `rsv_en`, `rsv_a`  in  1 / AW  reserve a register: set its busy bit.
- `busy_cnt`  out  AW+1  number of registers currently busy.

## Operation
- **Reset** (`rst_n` low, asynchronous, no clock needed):
  - all registers = 0, all busy bits = 0, `busy_cnt` = 0.
  - `rd` = 0 and `rbusy` = 0 on every port.
  - Reset wins over any same-cycle write or reserve.
- **Reads**
  - Combinational: `rd[i]` = reg[ra[i]] and `rbusy[i]` = busy[ra[i]].
  - With `ZERO_REG`=1 and `ra[i]`=0: `rd[i]` = 0 and `rbusy[i]` = 0 regardless of state.
- **Writes**
  - At the clock edge, `weN` stores `wdN` into reg[waN].
  - When both ports write the same address, `wd1` is stored.
  - With `ZERO_REG`=1, writes to address 0 are dropped.
- **Scoreboard**
  - Any accepted write clears busy[waN].
  - `rsv_en` sets busy[rsv_a].
  - When a reserve and a write target the same address in the same cycle, the reserve wins: the bit ends set. This models a new producer issued while the old one retires.
  - A reserve of an already-busy register leaves it busy; it is not counted twice.
  - A write to a non-busy register leaves its busy bit at 0.
- **busy_cnt**
  - Equals the population count of the busy bits after every edge.
  - Updated incrementally, with a net change from −2 to +1 per cycle.
  - Never wraps: the range is 0..DEPTH, or 0..DEPTH−1 with `ZERO_REG`.

## Timing
- Read latency: 0 cycles (combinational from `ra` and state).
- Write latency: data is visible on `rd` from the cycle after the edge.
  - With `REGFILE_BYPASS_EN` defined, data is visible in the same cycle (see Configuration).
- Scoreboard latency: a reserve or clear is visible on `rbusy` and `busy_cnt` from the cycle after the edge.
- No handshake. Writes and reserves are accepted unconditionally every cycle.
- Reset deassertion is synchronised upstream. The first edge after deassertion may carry valid writes.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- **Defined:** write-to-read forwarding.
  - If `weN` is high and `waN == ra[i]` (and not the zero register), `rd[i]` = `wdN` in the same cycle. Port 1 wins over port 0.
  - `rbusy[i]` = 0 in that cycle unless `rsv_en` with `rsv_a == ra[i]` is also asserted.
  - The forwarded value equals the value stored at the edge.
- **Undefined:** no forwarding.
  - `rd` and `rbusy` reflect registered state only.
  - A same-cycle write/read to one address returns the old value and old busy bit.
- Storage, scoreboard and `busy_cnt` behaviour are identical in both builds.

## Test plan
- **Reset:** after writing reg5 = 0xDEADBEEF and reserving reg7, pulse `rst_n` low mid-cycle.
  - → `rd` = 0 and `rbusy` = 0 immediately on all ports; `busy_cnt` = 0.
- **Dual-write collision:** `we0` reg3 = 0x11111111 and `we1` reg3 = 0x22222222 in the same edge.
  - → next cycle, `ra[0]`=3 reads 0x22222222.
- **Zero register:** write reg0 = 0xFFFFFFFF and `rsv_en` with `rsv_a`=0.
  - → `rd` = 0, `rbusy` = 0, `busy_cnt` unchanged.
- **Scoreboard:**
  - Reserve reg4, then reg9 → `busy_cnt` = 2.
  - Write reg4 with a same-cycle reserve of reg4 → reg4 stays busy, `busy_cnt` = 2.
  - Write reg4 and reg9 on both ports → `busy_cnt` = 0.
  - Reserve every register (DEPTH=8, `ZERO_REG`=0) → `busy_cnt` = 8, no wrap.
- **Bypass:** with `ra[1]`=6 and reg6 = 0 while busy, assert `we0` reg6 = 0xA5A5A5A5.
  - Defined → same cycle `rd[1]` = 0xA5A5A5A5, `rbusy[1]` = 0.
  - Undefined → `rd[1]` = 0, `rbusy[1]` = 1 until the next cycle.
- **Parameter sweep:** run with WIDTH=16, DEPTH=64, NRD=4, driving random writes and reserves against a reference model.
  - → all `rd`, `rbusy` and `busy_cnt` values match the model every cycle.
